// File: rtl/dual_port_ram_pkg.sv
// Shared constants and helpers for the dual_port_ram block.
// Optional write-first bypass is enabled by defining DUAL_PORT_RAM_BYPASS_EN.
package dual_port_ram_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int ADDR_WIDTH_DEF = 4;

    function automatic int depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/dual_port_ram_rd_port.sv
// One read port: registered output that holds while not enabled, with a
// bypass mux that selects same-cycle write data when the top flags a hit.
module dual_port_ram_rd_port
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  re_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  bypass_hit_i,
    input  logic [DATA_WIDTH-1:0] bypass_data_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;

    always_comb begin
        dout_d = dout_q;
        if (re_i) begin
            dout_d = bypass_hit_i ? bypass_data_i : mem_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM, single clock, port 1 wins same-address write collisions.
// Define DUAL_PORT_RAM_BYPASS_EN for write-first reads; default is read-first.
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we1,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic [DATA_WIDTH-1:0] dout1,
    input  logic                  we2,
    input  logic                  re2,
    input  logic [ADDR_WIDTH-1:0] addr2,
    input  logic [DATA_WIDTH-1:0] din2,
    output logic [DATA_WIDTH-1:0] dout2
);

    localparam int DEPTH = depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  same_addr;
    logic                  we2_eff;
    logic                  byp1_hit;
    logic                  byp2_hit;
    logic [DATA_WIDTH-1:0] byp1_data;
    logic [DATA_WIDTH-1:0] byp2_data;

    assign same_addr = (addr1 == addr2);
    // Port 2's write is dropped when port 1 writes the same word.
    assign we2_eff   = we2 && !(we1 && same_addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (we1) begin
                mem_q[addr1] <= din1;
            end
            if (we2_eff) begin
                mem_q[addr2] <= din2;
            end
        end
    end

`ifdef DUAL_PORT_RAM_BYPASS_EN
    // Port 1 data takes precedence, matching what the array stores.
    assign byp1_hit  = we1 || (we2 && same_addr);
    assign byp1_data = we1 ? din1 : din2;
    assign byp2_hit  = we2 || (we1 && same_addr);
    assign byp2_data = (we1 && same_addr) ? din1 : din2;
`else
    assign byp1_hit  = 1'b0;
    assign byp1_data = '0;
    assign byp2_hit  = 1'b0;
    assign byp2_data = '0;
`endif

    dual_port_ram_rd_port #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd_port1 (
        .clk_i        (clk),
        .reset_i      (reset),
        .re_i         (re1),
        .mem_data_i   (mem_q[addr1]),
        .bypass_hit_i (byp1_hit),
        .bypass_data_i(byp1_data),
        .dout_o       (dout1)
    );

    dual_port_ram_rd_port #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd_port2 (
        .clk_i        (clk),
        .reset_i      (reset),
        .re_i         (re2),
        .mem_data_i   (mem_q[addr2]),
        .bypass_hit_i (byp2_hit),
        .bypass_data_i(byp2_data),
        .dout_o       (dout2)
    );

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed bench for dual_port_ram with a per-port expected-data scoreboard.
module tb_dual_port_ram;

    localparam int DW    = 4;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          we1, re1, we2, re2;
    logic [AW-1:0] addr1, addr2;
    logic [DW-1:0] din1, din2;
    logic [DW-1:0] dout1, dout2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp1_q[$];
    logic [DW-1:0] exp2_q[$];
    logic [DW-1:0] model [DEPTH];
    logic [AW-1:0] log_q[$];

    always #5 clk = ~clk;

    dual_port_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .we1  (we1),
        .re1  (re1),
        .addr1(addr1),
        .din1 (din1),
        .dout1(dout1),
        .we2  (we2),
        .re2  (re2),
        .addr2(addr2),
        .din2 (din2),
        .dout2(dout2)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 1'b0;
        we1 = 1'b0; re1 = 1'b0; addr1 = '0; din1 = '0;
        we2 = 1'b0; re2 = 1'b0; addr2 = '0; din2 = '0;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we1 = 1'b1; addr1 = a; din1 = d;
    endtask

    task automatic wr2(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we2 = 1'b1; addr2 = a; din2 = d;
    endtask

    task automatic rd1(input logic [AW-1:0] a, input logic [DW-1:0] e);
        re1 = 1'b1; addr1 = a; exp1_q.push_back(e);
    endtask

    task automatic rd2(input logic [AW-1:0] a, input logic [DW-1:0] e);
        re2 = 1'b1; addr2 = a; exp2_q.push_back(e);
    endtask

    // Advance one edge, then compare any outputs the scoreboard expects.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (exp1_q.size() > 0) check({tag, "_dout1"}, dout1, exp1_q.pop_front());
        if (exp2_q.size() > 0) check({tag, "_dout2"}, dout2, exp2_q.pop_front());
        idle();
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rdw_exp;

        idle();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset then read
        reset = 1'b1;
        tick("reset");
        rd1(4'd3, 4'h0);
        rd2(4'd12, 4'h0);
        tick("reset_read");

        // Port 1 writes i to address i, port 2 reads them back
        for (int i = 0; i < DEPTH; i++) begin
            wr1(AW'(i), DW'(i));
            model[i] = DW'(i);
            tick("p1_fill");
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd2(AW'(i), model[i]);
            tick("p2_readback");
        end

        // Port 2 random writes, port 1 reads the logged addresses
        for (int i = 0; i < 16; i++) begin
            a = AW'($urandom_range(DEPTH - 1, 0));
            d = DW'($urandom_range((1 << DW) - 1, 0));
            wr2(a, d);
            model[a] = d;
            log_q.push_back(a);
            tick("p2_rand_wr");
        end
        while (log_q.size() > 0) begin
            a = log_q.pop_front();
            rd1(a, model[a]);
            tick("p1_rand_rd");
        end

        // Simultaneous write collision: port 1 wins
        wr1(4'd5, 4'hA);
        wr2(4'd5, 4'h3);
        model[5] = 4'hA;
        tick("collide_wr");
        rd2(4'd5, 4'hA);
        tick("collide_rd");

        // Read-during-write, cross-port
        wr1(4'd7, 4'h2);
        tick("rdw_setup");
`ifdef DUAL_PORT_RAM_BYPASS_EN
        rdw_exp = 4'h9;
`else
        rdw_exp = 4'h2;
`endif
        wr1(4'd7, 4'h9);
        rd2(4'd7, rdw_exp);
        tick("rdw");
        rd1(4'd7, 4'h9);
        tick("rdw_after");

        // Hold while re1 is low
        exp1_q.push_back(4'h9);
        tick("hold");

        // Mid-operation reset clears outputs and contents
        reset = 1'b1;
        exp1_q.push_back(4'h0);
        exp2_q.push_back(4'h0);
        tick("midop_reset");
        for (int i = 0; i < DEPTH; i++) begin
            rd1(AW'(i), 4'h0);
            rd2(AW'(DEPTH - 1 - i), 4'h0);
            tick("cleared");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
